// File: rtl/dff_pipe.sv
// dff_pipe: parametrised pipelined staging register.
// A chain of STAGES registers that shift together on 'write', with per-byte
// write enables into stage 0, a valid flag per stage, a synchronous flush
// and a registered occupancy count of valid stages.
module dff_pipe #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          STAGES    = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic                          flush,
  input  logic                          valid_in,
  input  logic [WIDTH/8-1:0]            be,
  input  logic [WIDTH-1:0]              next,
  output logic [WIDTH-1:0]              prev,
  output logic                          valid_out,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CW     = $clog2(STAGES + 1);

  // Stage 0 is the entry stage; stage STAGES-1 drives the outputs.
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [CW-1:0]                count_q, count_d;

  // Next-state: flush beats write, write shifts, otherwise everything holds.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      data_d  = {STAGES{RESET_VAL}};
      valid_d = '0;
      count_d = '0;
    end else if (write) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Unenabled bytes keep the old stage-0 value, which was also just
      // copied forward into stage 1.
      for (int unsigned i = 0; i < NBYTES; i++) begin
        data_d[0][8*i +: 8] = be[i] ? next[8*i +: 8] : data_q[0][8*i +: 8];
      end
      valid_d[0] = valid_in;
      // Incremental popcount: one flag enters, the old last flag leaves.
      count_d = count_q + CW'(valid_in) - CW'(valid_q[STAGES-1]);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= {STAGES{RESET_VAL}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    prev      = data_q[STAGES-1];
    valid_out = valid_q[STAGES-1];
    count     = count_q;
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Testbench for dff_pipe: one STAGES=1 and one STAGES=3 instance share the
// same inputs; a queue-based reference model predicts both.
module tb_dff_pipe;

  logic        clk = 1'b0;
  logic        reset, write, flush, valid_in;
  logic [3:0]  be;
  logic [31:0] nxt;

  logic [31:0] prev1, prev3;
  logic        vout1, vout3;
  logic        cnt1;
  logic [1:0]  cnt3;

  int passed = 0;
  int total  = 0;

  // Model: per instance a queue of stage data and valid flags, index 0 = entry.
  logic [31:0] md[2][$];
  bit          mv[2][$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .flush(flush),
    .valid_in(valid_in), .be(be), .next(nxt),
    .prev(prev1), .valid_out(vout1), .count(cnt1));

  dff_pipe #(.WIDTH(32), .STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .write(write), .flush(flush),
    .valid_in(valid_in), .be(be), .next(nxt),
    .prev(prev3), .valid_out(vout3), .count(cnt3));

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < md[d].size(); k++) begin
        md[d][k] = '0;
        mv[d][k] = 1'b0;
      end
  endtask

  task automatic model_edge();
    logic [31:0] mask, nd;
    mask = '0;
    for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
    if (reset || flush) model_clear();
    else if (write) begin
      for (int d = 0; d < 2; d++) begin
        nd = (md[d][0] & ~mask) | (nxt & mask);
        md[d].push_front(nd);
        void'(md[d].pop_back());
        mv[d].push_front(valid_in);
        void'(mv[d].pop_back());
      end
    end
  endtask

  function automatic int model_count(int d);
    int c = 0;
    foreach (mv[d][k]) c += int'(mv[d][k]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b1; flush = 1'b0; valid_in = 1'b1;
    be = 4'hF; nxt = 32'h1;
    model_clear();
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (prev3 !== 32'h0 || vout3 !== 1'b0 || cnt3 !== 2'd0)
        $display("FAIL reset3 cyc%0d got prev=%h v=%b c=%0d want 0/0/0", c, prev3, vout3, cnt3);
      else passed++;
      total++; if (prev1 !== 32'h0 || vout1 !== 1'b0 || cnt1 !== 1'b0)
        $display("FAIL reset1 cyc%0d got prev=%h v=%b c=%0d want 0/0/0", c, prev1, vout1, cnt1);
      else passed++;
      if (c < 2) tick();
    end
    reset = 1'b0;
    write = 1'b0;
    #2;
    total++; if (prev3 !== 32'h0 || cnt3 !== 2'd0 || prev1 !== 32'h0)
      $display("FAIL release got prev3=%h c3=%0d prev1=%h want 0", prev3, cnt3, prev1);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_write_hold();
    write = 1'b1; be = 4'hF; nxt = 32'h12345678; valid_in = 1'b1;
    tick();
    total++; if (prev1 !== 32'h12345678 || vout1 !== 1'b1 || cnt1 !== 1'b1)
      $display("FAIL write1 got prev=%h v=%b c=%0d want 12345678/1/1", prev1, vout1, cnt1);
    else passed++;
    write = 1'b0; nxt = 32'h87654321;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (prev1 !== 32'h12345678 || cnt1 !== 1'b1)
        $display("FAIL hold1 cyc%0d got prev=%h c=%0d want 12345678/1", c, prev1, cnt1);
      else passed++;
    end
  endtask

  task automatic test_byte_enable();
    write = 1'b1; be = 4'b0101; nxt = 32'hAABBCCDD; valid_in = 1'b1;
    tick();
    total++; if (prev1 !== 32'h12BB56DD)
      $display("FAIL byte_en got %h want 12BB56DD", prev1);
    else passed++;
  endtask

  task automatic test_delay();
    logic [31:0] vals[4] = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
    logic [31:0] want_prev;
    write = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (prev3 !== 32'h0 || cnt3 !== 2'd0 || vout3 !== 1'b0)
      $display("FAIL flush_clear got prev=%h c=%0d v=%b want 0/0/0", prev3, cnt3, vout3);
    else passed++;
    be = 4'hF; valid_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      write = 1'b1; nxt = vals[n];
      tick();
      want_prev = (n == 2) ? vals[0] : 32'h0;
      total++; if (prev3 !== want_prev || cnt3 !== 2'(n + 1))
        $display("FAIL fill%0d got prev=%h c=%0d want %h/%0d", n, prev3, cnt3, want_prev, n + 1);
      else passed++;
    end
    write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (prev3 !== vals[0] || cnt3 !== 2'd3 || vout3 !== 1'b1)
        $display("FAIL stall%0d got prev=%h c=%0d want %h/3", c, prev3, cnt3, vals[0]);
      else passed++;
    end
    write = 1'b1; nxt = vals[3]; valid_in = 1'b0;
    tick();
    total++; if (prev3 !== vals[1] || cnt3 !== 2'd2)
      $display("FAIL drop_valid got prev=%h c=%0d want %h/2", prev3, cnt3, vals[1]);
    else passed++;
  endtask

  task automatic test_flush_beats_write();
    write = 1'b1; be = 4'hF; valid_in = 1'b1;
    for (int n = 0; n < 3; n++) begin nxt = 32'hE0 + 32'(n); tick(); end
    total++; if (cnt3 !== 2'd3)
      $display("FAIL full got c=%0d want 3", cnt3);
    else passed++;
    flush = 1'b1; nxt = 32'hDDDD_DDDD;
    tick();
    flush = 1'b0;
    total++; if (prev3 !== 32'h0 || vout3 !== 1'b0 || cnt3 !== 2'd0)
      $display("FAIL flush_wr got prev=%h v=%b c=%0d want 0/0/0", prev3, vout3, cnt3);
    else passed++;
    be = 4'h0; valid_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++; if (prev3 !== 32'h0 || cnt3 !== 2'd0)
        $display("FAIL no_load%0d got prev=%h c=%0d want 0/0", n, prev3, cnt3);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    write = 1'b1; be = 4'hF; valid_in = 1'b1;
    nxt = 32'h1111_1111; tick();
    nxt = 32'h2222_2222; tick();
    total++; if (cnt3 !== 2'd2)
      $display("FAIL pre_rst got c=%0d want 2", cnt3);
    else passed++;
    #2 reset = 1'b1;
    model_clear();
    #1;
    total++; if (prev3 !== 32'h0 || cnt3 !== 2'd0 || vout3 !== 1'b0 || prev1 !== 32'h0 || cnt1 !== 1'b0)
      $display("FAIL async_rst got prev3=%h c3=%0d v3=%b prev1=%h c1=%0d want zeros",
               prev3, cnt3, vout3, prev1, cnt1);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ep;
    int ec;
    for (int n = 0; n < 400; n++) begin
      write    = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 29) == 0);
      valid_in = 1'($urandom);
      be       = 4'($urandom);
      nxt      = $urandom;
      tick();
      ep = md[0][0]; ec = model_count(0);
      total++; if (prev1 !== ep || vout1 !== mv[0][0] || int'(cnt1) != ec)
        $display("FAIL rand1 it%0d got prev=%h v=%b c=%0d want %h/%b/%0d",
                 n, prev1, vout1, cnt1, ep, mv[0][0], ec);
      else passed++;
      ep = md[1][2]; ec = model_count(1);
      total++; if (prev3 !== ep || vout3 !== mv[1][2] || int'(cnt3) != ec)
        $display("FAIL rand3 it%0d got prev=%h v=%b c=%0d want %h/%b/%0d",
                 n, prev3, vout3, cnt3, ep, mv[1][2], ec);
      else passed++;
    end
    flush = 1'b0;
  endtask

  initial begin
    md[0].push_back('0); mv[0].push_back(1'b0);
    for (int k = 0; k < 3; k++) begin md[1].push_back('0); mv[1].push_back(1'b0); end
    test_reset();
    test_write_hold();
    test_byte_enable();
    test_delay();
    test_flush_beats_write();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
